mmul_regb_ctrl: RTL
===================

Name: mmul_regb_ctrl

Overview:
- Sequencer for the 257-bit Montgomery-multiplier operand-B shift register: 16-bit write-in, 16-bit cyclic right rotate, 1-bit left shift.
- Accepts one command at a time and drives the register's we/sel_cyc/sel_ls strobes:
  - LOAD: 16 words from an upstream valid/ready stream.
  - ROT: 16 words out to the MMUL core, which restores the register.
  - SHL: N single-bit left shifts.
- Sits between the modular-arithmetic top controller and the operand-B register.

Parameters:
- WORD_W, 16, word width of register port and data streams.
- NWORDS, 16, words per 256-bit operand; also the LOAD and ROT beat count.
- SHL_W, 9, width of the shift-count field; max 511 shifts.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 LOAD, 01 ROT, 10 SHL, 11 NOP.
- cmd_len  in  SHL_W  shift count, used by SHL only.
- din_valid  in  1  load word offered.
- din_ready  out  1  high only in LOAD.
- din_data  in  WORD_W  load word.
- dout_valid  out  1  high only in ROT.
- dout_ready  in  1  consumer accepts word.
- dout_data  out  WORD_W  word driven to consumer; equals reg_regout.
- reg_regin  out  WORD_W  to register regin; equals din_data.
- reg_we  out  1  register write/shift enable.
- reg_sel_cyc  out  1  1 selects rotate path.
- reg_sel_ls  out  1  1 selects left shift.
- reg_regout  in  WORD_W  register low word.
- reg_b256  in  1  register bit 256.
- done  out  1  one-cycle completion pulse.
- ovf  out  1  sticky: bit 256 set after SHL.

Behaviour:
- Reset values: state IDLE; cmd_ready=1; din_ready, dout_valid, reg_we, reg_sel_cyc, reg_sel_ls, done, ovf = 0; beat counter and shift counter = 0. The register datapath itself is not reset.
- States and transitions:
  - IDLE -> LOAD/ROT/SHL/FIN when cmd_valid & cmd_ready.
  - cmd_op and cmd_len are latched on that accept.
  - NOP goes directly to FIN.
- LOAD:
  - Each din handshake drives reg_we=1, sel_cyc=0, sel_ls=0 in the same cycle; the word is combinational from din_data.
  - Beat counter increments per handshake; after NWORDS beats -> FIN.
  - No handshake means no strobe.
  - ovf clears on LOAD accept.
- ROT:
  - dout_valid=1. Each dout handshake drives reg_we=1, sel_cyc=1, sel_ls=0, rotating the register 16 bits right.
  - After NWORDS handshakes the register is back in its original state -> FIN.
  - The first word out is the low word of the operand.
- SHL:
  - Counter is loaded with cmd_len; reg_we=1, sel_ls=1 every cycle while the counter is nonzero; decrement per cycle.
  - cmd_len=0 goes to FIN with zero shifts.
  - On reaching FIN from SHL, ovf |= reg_b256, sampled in the FIN cycle after the last shift has landed.
- FIN: done=1 for exactly one cycle -> IDLE.
- Latency (accept cycle to done):
  - LOAD/ROT: NWORDS+1 cycles with no stalls.
  - SHL: cmd_len+1 cycles.
  - NOP: 1 cycle.
- Strobe rules:
  - reg_we is never asserted in IDLE or FIN.
  - reg_sel_cyc and reg_sel_ls are never both 1.
- Streams:
  - din_valid outside LOAD and dout_ready outside ROT are ignored.
  - cmd_valid outside IDLE is held off by cmd_ready=0.
- Reset asserted mid-command: immediate return to IDLE with all strobes low. Register contents are undefined for the aborted operation; the next LOAD rewrites all 16 words.

Optional Feature:
- Macro MMUL_REGB_CTRL_PERF_EN.
- Defined:
  - Adds output stall_cnt [15:0], counting cycles spent in LOAD with din_valid=0 plus cycles in ROT with dout_ready=0.
  - Saturates at 0xFFFF; clears on any cmd accept; reset 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package mmul_pkg:
  - cmd opcode constants (OP_LOAD=2'b00, OP_ROT=2'b01, OP_SHL=2'b10, OP_NOP=2'b11).
  - State encoding enum (IDLE, LOAD, ROT, SHL, FIN).
  - WORD_W/NWORDS defaults.
- One natural sub-module, mmul_regb_strobe: combinational decode of state plus handshakes into reg_we/sel_cyc/sel_ls, reused for the operand-A controller.

Test Plan:
- LOAD words 0x0001..0x0010 with din_valid always high -> 16 reg_we pulses with sel_cyc=0; done at cycle 17 after accept; din_ready low afterward.
- LOAD then ROT, with dout_ready toggled 1/0 -> dout_data sequence 0x0001..0x0010; exactly 16 rotate strobes; done after the 16th handshake; a second ROT returns the same sequence.
- SHL cmd_len=3 on an operand whose top bits are 0b111 -> exactly 3 consecutive sel_ls strobes; done 4 cycles after accept; ovf=1. A following SHL cmd_len=0 -> done after 1 cycle; ovf stays 1. A following LOAD -> ovf=0.
- NOP -> done pulse in the cycle after accept; no reg_we.
- rst_n pulled low in ROT after 5 handshakes -> state IDLE asynchronously; all strobes 0, done 0, cmd_ready 1; a subsequent LOAD completes normally.
- With MMUL_REGB_CTRL_PERF_EN: LOAD with 4 idle din cycles inserted -> stall_cnt=4 at done; cleared to 0 on the next accept.

Source files
------------

// File: rtl/mmul_pkg.sv
// Shared definitions for the Montgomery-multiplier operand register controllers:
// command opcodes, controller state encoding and default operand geometry.
package mmul_pkg;

    localparam int MMUL_WORD_W = 16;
    localparam int MMUL_NWORDS = 16;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ROT  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ROT  = 3'd2,
        SHL  = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/mmul_regb_strobe.sv
// Combinational decode of controller state and stream handshakes into the
// operand register write/rotate/left-shift strobes.
module mmul_regb_strobe
    import mmul_pkg::*;
(
    input  logic [2:0] state,
    input  logic       din_valid,
    input  logic       din_ready,
    input  logic       dout_valid,
    input  logic       dout_ready,
    input  logic       shl_nz,
    output logic       we,
    output logic       sel_cyc,
    output logic       sel_ls
);

    logic load_hs;
    logic rot_hs;
    logic shl_step;

    assign load_hs  = (state == LOAD) && din_valid && din_ready;
    assign rot_hs   = (state == ROT) && dout_valid && dout_ready;
    assign shl_step = (state == SHL) && shl_nz;

    // Rotate and shift are decoded from disjoint states, so they never overlap.
    assign we      = load_hs || rot_hs || shl_step;
    assign sel_cyc = rot_hs;
    assign sel_ls  = shl_step;

endmodule

// File: rtl/mmul_regb.sv
// Top: mmul_regb_ctrl, sequencer for the 257-bit operand-B shift register.
// Optional stall counter output enabled by macro MMUL_REGB_CTRL_PERF_EN.
module mmul_regb_ctrl
    import mmul_pkg::*;
#(
    parameter int WORD_W = MMUL_WORD_W,
    parameter int NWORDS = MMUL_NWORDS,
    parameter int SHL_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SHL_W-1:0]  cmd_len,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [WORD_W-1:0] din_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [WORD_W-1:0] dout_data,
    output logic [WORD_W-1:0] reg_regin,
    output logic              reg_we,
    output logic              reg_sel_cyc,
    output logic              reg_sel_ls,
    input  logic [WORD_W-1:0] reg_regout,
    input  logic              reg_b256,
`ifdef MMUL_REGB_CTRL_PERF_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              done,
    output logic              ovf
);

    localparam int CNT_W = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NWORDS - 1);

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] beat_cnt;
    logic [SHL_W-1:0] shl_cnt;
    logic             din_hs;
    logic             dout_hs;
    logic             accept;

    assign din_hs  = din_valid && din_ready;
    assign dout_hs = dout_valid && dout_ready;
    assign accept  = cmd_valid && cmd_ready;

    assign reg_regin = din_data;
    assign dout_data = reg_regout;

    mmul_regb_strobe u_strobe (
        .state      (state),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .shl_nz     (shl_cnt != '0),
        .we         (reg_we),
        .sel_cyc    (reg_sel_cyc),
        .sel_ls     (reg_sel_ls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= OP_NOP;
            beat_cnt   <= '0;
            shl_cnt    <= '0;
            cmd_ready  <= 1'b1;
            din_ready  <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= cmd_op;
                        beat_cnt  <= '0;
                        shl_cnt   <= cmd_len;
                        cmd_ready <= 1'b0;
                        case (cmd_op)
                            OP_LOAD: begin
                                state     <= LOAD;
                                din_ready <= 1'b1;
                                ovf       <= 1'b0;
                            end
                            OP_ROT: begin
                                state      <= ROT;
                                dout_valid <= 1'b1;
                            end
                            OP_SHL: begin
                                if (cmd_len != '0) begin
                                    state <= SHL;
                                end else begin
                                    state <= FIN;
                                    done  <= 1'b1;
                                end
                            end
                            default: begin
                                state <= FIN;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
                LOAD: begin
                    if (din_hs) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state     <= FIN;
                            din_ready <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                ROT: begin
                    if (dout_hs) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT) begin
                            state      <= FIN;
                            dout_valid <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                SHL: begin
                    shl_cnt <= shl_cnt - SHL_W'(1);
                    if (shl_cnt == SHL_W'(1)) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    // The last shift has landed by now, so bit 256 is final.
                    if (op_q == OP_SHL) begin
                        ovf <= ovf | reg_b256;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cmd_ready  <= 1'b1;
                    din_ready  <= 1'b0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MMUL_REGB_CTRL_PERF_EN
    logic stall;

    assign stall = ((state == LOAD) && !din_valid) || ((state == ROT) && !dout_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
